// File: rtl/baud_rate_generator_frac.sv
// Fractional clk divider giving oversample, mid-bit and bit strobes; ticks decode combinationally from registered count.
// No backpressure: enable low freezes the counters, restart realigns phase; rate changes land at period boundaries.
module baud_rate_generator_frac #(
    parameter int DVSR_W     = 11,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16,
    parameter int PH_W       = $clog2(OVERSAMPLE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              restart,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [FRAC_W-1:0] frac,
    output logic              sample_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic [PH_W-1:0]   phase
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);

    logic [DVSR_W:0]   r_count;
    logic [FRAC_W-1:0] r_acc;
    logic              r_stretch;
    logic [PH_W-1:0]   r_phase;
    logic [DVSR_W-1:0] r_act_dvsr;
    logic [FRAC_W-1:0] r_act_frac;

    logic [DVSR_W:0]   w_limit;
    logic [FRAC_W:0]   w_sum;
    logic              w_tick;

    // The carry out of the fraction accumulator lengthens the next period by one cycle.
    assign w_limit = {1'b0, r_act_dvsr} + {{DVSR_W{1'b0}}, r_stretch};
    assign w_sum   = {1'b0, r_acc} + {1'b0, r_act_frac};
    assign w_tick  = reset & enable & ~restart & (r_count == w_limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_stretch  <= 1'b0;
            r_phase    <= '0;
            r_act_dvsr <= '0;
            r_act_frac <= '0;
        end else if (restart) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_stretch  <= 1'b0;
            r_phase    <= '0;
            r_act_dvsr <= dvsr;
            r_act_frac <= frac;
        end else if (w_tick) begin
            r_count              <= '0;
            {r_stretch, r_acc}   <= w_sum;
            r_phase              <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
            r_act_dvsr           <= dvsr;
            r_act_frac           <= frac;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end else begin
            // Frozen: the active configuration follows the inputs so it is current on resume.
            r_act_dvsr <= dvsr;
            r_act_frac <= frac;
        end
    end

    assign sample_tick = w_tick;
    assign mid_tick    = w_tick & (r_phase == PH_MID);
    assign bit_tick    = w_tick & (r_phase == PH_LAST);
    assign phase       = r_phase;

endmodule

// File: tb/tb_baud_rate_generator_frac.sv
// Bench for baud_rate_generator_frac: directed timing scenarios plus randomized traffic against a period-level model.
module tb_baud_rate_generator_frac;

    localparam int DVSR_W = 11;
    localparam int FRAC_W = 4;
    localparam int OS     = 16;
    localparam int PH_W   = $clog2(OS);
    localparam int FMOD   = 1 << FRAC_W;
    localparam int CMOD   = 1 << (DVSR_W + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic              restart = 1'b0;
    logic [DVSR_W-1:0] dvsr = '0;
    logic [FRAC_W-1:0] frac = '0;
    logic              sample_tick, mid_tick, bit_tick;
    logic [PH_W-1:0]   phase;

    baud_rate_generator_frac #(.DVSR_W(DVSR_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS)) dut (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .dvsr(dvsr), .frac(frac), .sample_tick(sample_tick),
        .mid_tick(mid_tick), .bit_tick(bit_tick), .phase(phase)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Period-level model: elapsed enabled cycles in the current period, its length
    // (active divisor + 1 + owed extra cycle), running fraction sum and ticks since restart.
    int m_pos = 0, m_ad = 0, m_af = 0, m_extra = 0, m_fsum = 0, m_ticks = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pos = 0; m_ad = 0; m_af = 0; m_extra = 0; m_fsum = 0; m_ticks = 0;
        end else if (restart) begin
            m_pos = 0; m_extra = 0; m_fsum = 0; m_ticks = 0;
            m_ad = int'(dvsr); m_af = int'(frac);
        end else if (enable) begin
            if (m_pos == m_ad + m_extra) begin
                m_ticks++;
                m_extra = ((m_fsum + m_af) >= FMOD) ? 1 : 0;
                m_fsum  = (m_fsum + m_af) % FMOD;
                m_ad    = int'(dvsr);
                m_af    = int'(frac);
                m_pos   = 0;
            end else begin
                m_pos = (m_pos + 1) % CMOD;
            end
        end else begin
            m_ad = int'(dvsr);
            m_af = int'(frac);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            bit e_t;
            int e_ph;
            e_t  = reset && enable && !restart && (m_pos == m_ad + m_extra);
            e_ph = m_ticks % OS;
            chk("sample_tick", int'(sample_tick), int'(e_t));
            chk("mid_tick", int'(mid_tick), int'(e_t && e_ph == OS / 2 - 1));
            chk("bit_tick", int'(bit_tick), int'(e_t && e_ph == OS - 1));
            chk("phase", int'(phase), e_ph);
        end
    end

    task automatic do_restart(input int dv, input int fr, output int t0);
        @(posedge clk); #1;
        dvsr = DVSR_W'(dv); frac = FRAC_W'(fr); restart = 1'b1; enable = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic wait_tick(output int t, output int m, output int b, output int ph);
        t = -1; m = 0; b = 0; ph = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sample_tick) begin
                t = cyc; m = int'(mid_tick); b = int'(bit_tick); ph = int'(phase);
                return;
            end
        end
        errs++; checks++;
        $display("FAIL tick_timeout: got no tick expected one within 300 cycles");
    endtask

    int tt[64], mm[64], bb[64], pp[64];
    int t0, a, b, c, m, bt, ph, ph_a;
    int exp_iv[8] = '{5, 5, 6, 5, 6, 5, 6, 5};

    initial begin
        enable = 1'b1;
        #1;
        chk("reset_tick", int'(sample_tick), 0);
        chk("reset_phase", int'(phase), 0);
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Integer divide by 5, phase progression
        do_restart(4, 0, t0);
        for (int k = 0; k < 32; k++) wait_tick(tt[k], mm[k], bb[k], pp[k]);
        chk("int_first_tick", tt[0] - t0, 5);
        chk("int_tick2", tt[1] - t0, 10);
        chk("int_mid_time", tt[7] - t0, 40);
        chk("int_mid_flag", mm[7], 1);
        chk("int_mid_not_early", mm[6], 0);
        chk("int_bit_time", tt[15] - t0, 80);
        chk("int_bit_flag", bb[15], 1);
        chk("int_phase15", pp[15], 15);
        chk("int_phase_wrap", pp[16], 0);
        chk("int_bit2_time", tt[31] - t0, 160);
        chk("int_bit2_flag", bb[31], 1);

        // Fractional divide 5.5
        do_restart(4, 8, t0);
        for (int k = 0; k < 64; k++) wait_tick(tt[k], mm[k], bb[k], pp[k]);
        chk("frac_iv0", tt[0] - t0, exp_iv[0]);
        for (int k = 1; k < 8; k++) chk("frac_iv", tt[k] - tt[k-1], exp_iv[k]);
        chk("frac_8th", tt[7] - t0, 43);
        chk("frac_64th", tt[63] - t0, 351);

        // Rate change mid-period only applies after the next wrap
        do_restart(4, 0, t0);
        wait_tick(a, m, bt, ph);
        @(posedge clk); #1;
        @(posedge clk); #1;
        dvsr = 8;
        wait_tick(b, m, bt, ph);
        wait_tick(c, m, bt, ph);
        chk("rate_old_iv", b - a, 5);
        chk("rate_new_iv", c - b, 9);

        // Restart mid-period at count 2, phase 5
        do_restart(4, 0, t0);
        for (int k = 0; k < 5; k++) wait_tick(a, m, bt, ph);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_phase_before", int'(phase), 5);
        restart = 1'b1; t0 = cyc;
        @(negedge clk);
        chk("rst_mid_no_tick", int'(sample_tick), 0);
        @(posedge clk); #1;
        restart = 1'b0;
        chk("rst_mid_phase_after", int'(phase), 0);
        wait_tick(a, m, bt, ph);
        chk("rst_mid_next_tick", a - t0, 5);
        // Restart landing on a tick cycle
        repeat (5) @(posedge clk);
        #1;
        restart = 1'b1; t0 = cyc;
        @(negedge clk);
        chk("rst_on_tick_suppressed", int'(sample_tick), 0);
        @(posedge clk); #1;
        restart = 1'b0;
        chk("rst_on_tick_phase", int'(phase), 0);
        wait_tick(a, m, bt, ph);
        chk("rst_on_tick_next", a - t0, 5);

        // Enable gap of 3 cycles at count 2
        do_restart(4, 0, t0);
        wait_tick(a, m, bt, ph_a);
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        chk("gap_phase_held", int'(phase), (ph_a + 1) % OS);
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
        wait_tick(b, m, bt, ph);
        chk("gap_interval", b - a, 8);
        chk("gap_phase_next", ph, (ph_a + 1) % OS);

        // Asynchronous reset between edges
        repeat (7) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("areset_tick", int'(sample_tick), 0);
        chk("areset_mid", int'(mid_tick), 0);
        chk("areset_bit", int'(bit_tick), 0);
        chk("areset_phase", int'(phase), 0);
        @(negedge clk); #2 reset = 1'b1;
        do_restart(4, 0, t0);
        wait_tick(a, m, bt, ph);
        chk("areset_first_tick", a - t0, 5);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            @(posedge clk); #1;
            r = $urandom_range(0, 63);
            restart = (r == 0);
            if (r >= 1 && r <= 3) begin
                dvsr = DVSR_W'($urandom_range(0, 12));
                frac = FRAC_W'($urandom);
                enable = 1'b1;
            end else if ($urandom_range(0, 7) == 0 && int'(dvsr) == m_ad) begin
                enable = 1'b0;
            end else begin
                enable = 1'b1;
            end
        end
        @(posedge clk); #1;
        restart = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/baud_rate_generator_frac.md
# baud_rate_generator_frac

Parametrised fractional baud-tick generator for the thermometer's UART transmit and receive paths. It divides `clk` by a programmable integer-plus-fraction ratio to produce an oversampling `sample_tick`. A phase counter on top of that produces a per-bit `bit_tick` and a mid-bit `mid_tick` for receiver centre sampling. Rate changes take effect only at period boundaries, so they never produce a runt period. A synchronous `restart` lets the receiver realign phase on a start-bit edge.

## Interface
- `DVSR_W`, 11: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor. The fraction is `frac`/2^FRAC_W; FRAC_W ≥ 1.
- `OVERSAMPLE`, 16: sample ticks per bit. Must be ≥ 2; need not be a power of two.
- `PH_W`, $clog2(OVERSAMPLE): phase counter width (derived; do not override).
- `clk`, in, 1: single clock. All state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset. Low clears all state immediately.
- `enable`, in, 1: high means the counters run; low means they freeze.
- `restart`, in, 1: synchronous clear of counter, accumulator and phase; also loads the configuration.
- `dvsr`, in, DVSR_W: integer divisor. The nominal period is dvsr+1 clk cycles.
- `frac`, in, FRAC_W: fractional extension of the period.
- `sample_tick`, out, 1: one-cycle oversampling strobe.
- `mid_tick`, out, 1: high with the sample_tick where phase == OVERSAMPLE/2 − 1 (integer division).
- `bit_tick`, out, 1: high with the sample_tick where phase == OVERSAMPLE − 1.
- `phase`, out, PH_W: current sample index within the bit, range 0..OVERSAMPLE−1.

## Operation
- **State registers:**
  - `count` (DVSR_W+1 bits)
  - `acc` (FRAC_W bits)
  - `stretch` (1 bit)
  - `phase`
  - `act_dvsr` and `act_frac` (active configuration)
- **Reset:** all state registers are 0 while `reset` is low. All outputs are 0 during and after reset until the first tick.
- **Limit:** `limit` = act_dvsr + stretch, computed at DVSR_W+1 bits with no overflow. A `limit` of 0 gives a tick every enabled cycle.
- **Tick decode:** `sample_tick` = enable & ~restart & (count == limit). It is decoded from registered state and must be glitch-free. `mid_tick` and `bit_tick` are `sample_tick` ANDed with their phase compare.
- **Enabled edge, no tick:** count increments by 1.
- **Wrap edge** (`sample_tick` high):
  - count ← 0.
  - {stretch, acc} ← acc + act_frac. This addition uses the pre-update act_frac.
  - phase ← phase+1, or 0 when phase == OVERSAMPLE−1.
  - act_dvsr ← dvsr and act_frac ← frac.
- **enable low:** count, acc, stretch and phase hold. act_dvsr/act_frac track the `dvsr`/`frac` inputs every cycle. No ticks are produced.
- **restart high:** overrides enable.
  - count, acc, stretch and phase ← 0.
  - act_dvsr/act_frac ← inputs.
  - All ticks are suppressed that cycle.
- **Period length:** average period = dvsr+1+frac/2^FRAC_W cycles. Each individual period is either dvsr+1 or dvsr+2 cycles.

## Timing
- **First tick:** with restart or reset released and enable high from edge 1, sample_tick is high in the cycle after edge act_dvsr+1. Subsequent ticks follow every limit+1 cycles.
- **Ticks:** all ticks are exactly one clk cycle wide. mid_tick and bit_tick always coincide with a sample_tick.
- **Config latency:** a dvsr/frac change while enabled affects only the period that starts after the next wrap edge. The current period completes at its old length.
- **Restart with wrap:** restart coinciding with a would-be tick gives no tick that cycle. phase goes to 0, not phase+1.
- **Enable gaps:** enable low for N cycles delays every later tick by exactly N cycles.
- **Reset mid-period:** outputs go to 0 asynchronously. After `reset` rises, timing restarts from count=0 and act_* = 0 until the first wrap or restart loads the inputs. The bench must pulse restart after reset to load the divisor.

## Test plan
- **Integer divide and phase:** reset, restart with dvsr=4, frac=0, enable=1 (OVERSAMPLE=16).
  - sample_tick is high every 5th cycle.
  - mid_tick is high on the 8th tick (cycle 40); bit_tick on the 16th (cycle 80), then every 80 cycles.
  - phase counts 0..15.
- **Fractional divide:** dvsr=4, frac=8 (FRAC_W=4), restart.
  - Tick intervals are 5,5,6,5,6,5,6,5.
  - The 8th tick lands at cycle 43.
  - Long-run average is 5.5 cycles.
- **Glitch-free rate change:** dvsr changed 4→8 two cycles after a tick.
  - The next tick is still 5 cycles after the previous one.
  - The following interval is 9 cycles.
- **Restart mid-period:** restart asserted at count=2 with phase=5.
  - No tick that cycle; phase=0.
  - The next tick is dvsr+1=5 cycles after the restart edge.
  - Restart asserted on a tick cycle suppresses that tick.
- **Enable gap:** enable low for 3 cycles at count=2 with dvsr=4.
  - That tick arrives at interval 8 instead of 5.
  - phase and acc are unchanged across the gap.
- **Async reset mid-operation:** reset pulled low between clock edges.
  - All outputs and phase are 0 before the next edge.
  - After release plus restart with dvsr=4, the first tick is 5 cycles after the restart edge.
